cos_osc_ctrl: RTL and testbench

Phase-accumulator oscillator front-end acting as the requesting side of the cosine ALU's `do_calc`/`calc_done` handshake. On each sample tick it reduces the accumulated phase to a first-quadrant angle in Q2.16 radians and issues one cosine request. It then waits for the ALU's one-cycle result strobe, applies the quadrant sign, and presents one signed Q1.16 sample to the synth voice path.

---
 rtl/cos_osc_ctrl_pkg.sv | 31 +++
 rtl/cos_osc_ctrl_phase_quadrant_reduce.sv | 28 ++
 rtl/cos_osc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cos_osc_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cos_osc_ctrl_pkg.sv
// Shared constants, state encoding and the angle-scaling helper for the
// cosine oscillator front-end.
package cos_osc_ctrl_pkg;

    // Q-format widths
    localparam int Q_FRAC_W = 16;            // fractional bits of Q2.16 / Q1.16
    localparam int ANGLE_W  = 18;            // Q2.16 angle to the ALU
    localparam int SAMPLE_W = 18;            // Q1.16 sample / ALU result
    localparam int FR_W     = Q_FRAC_W + 1;  // reduced fraction, 0..0x10000
    localparam int SMP_W    = Q_FRAC_W + 2;  // quadrant bits + fraction bits

    localparam logic [ANGLE_W-1:0]  HALF_PI_Q2_16 = 18'h19220;
    localparam logic [SAMPLE_W-1:0] ONE_Q1_16     = 18'h10000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } state_e;

    // Scale a first-quadrant fraction (0..1.0 of a quarter turn) to radians.
    // The largest input 0x10000 maps exactly onto HALF_PI_Q2_16.
    function automatic logic [ANGLE_W-1:0] fr_to_angle(input logic [FR_W-1:0] fr);
        logic [FR_W+ANGLE_W-1:0] prod;
        prod = {{ANGLE_W{1'b0}}, fr} * {{FR_W{1'b0}}, HALF_PI_Q2_16};
        return ANGLE_W'(prod >> Q_FRAC_W);
    endfunction

endpackage

// File: rtl/cos_osc_ctrl_phase_quadrant_reduce.sv
// phase_quadrant_reduce: folds the top bits of a phase word into a
// first-quadrant fraction plus a sign flag for the cosine. Purely
// combinational so a sine path can share it with a different sign rule.
module phase_quadrant_reduce
    import cos_osc_ctrl_pkg::*;
(
    input  logic [SMP_W-1:0] phase_top_i,  // quadrant (2 bits) + fraction (16 bits)
    output logic [FR_W-1:0]  fr_o,         // reduced fraction, 0..0x10000
    output logic             neg_o         // cosine is negative in this quadrant
);

    logic [1:0]          quad;
    logic [Q_FRAC_W-1:0] frac;

    assign quad = phase_top_i[SMP_W-1 -: 2];
    assign frac = phase_top_i[Q_FRAC_W-1:0];

    // Odd quadrants run the fraction backwards; quadrants 1 and 2 are negative.
    always_comb begin
        if (quad[0]) begin
            fr_o = ONE_Q1_16[FR_W-1:0] - {1'b0, frac};
        end else begin
            fr_o = {1'b0, frac};
        end
        neg_o = quad[0] ^ quad[1];
    end

endmodule

// File: rtl/cos_osc_ctrl.sv
// cos_osc_ctrl: phase-accumulator oscillator that requests one cosine per
// sample tick from the cosine ALU and emits a signed Q1.16 sample.
// Optional WAIT timeout is enabled by defining COS_OSC_TIMEOUT_EN.
module cos_osc_ctrl
    import cos_osc_ctrl_pkg::*;
#(
    parameter int unsigned PHASE_W        = 24,
    parameter int unsigned TIMEOUT_CYCLES = 63
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [PHASE_W-1:0]  freq_step,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err,
    output logic [ANGLE_W-1:0]  cos_x,
    output logic                cos_do_calc,
    input  logic [SAMPLE_W-1:0] cos_result,
    input  logic                cos_calc_done,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid
);

    state_e state_q, state_d;

    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [SMP_W-1:0]    phase_smp_q, phase_smp_d;  // only the bits the reduction uses
    logic [ANGLE_W-1:0]  cos_x_q, cos_x_d;
    logic                neg_q, neg_d;
    logic                do_calc_q, do_calc_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic [FR_W-1:0]     red_fr;
    logic                red_neg;
    logic                tmo_hit;

    phase_quadrant_reduce u_reduce (
        .phase_top_i (phase_smp_q),
        .fr_o        (red_fr),
        .neg_o       (red_neg)
    );

`ifdef COS_OSC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             tmo_err_q, tmo_err_d;

    // Last WAIT cycle of the budget; the counter starts at 0 on WAIT entry.
    assign tmo_hit = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter and sticky timeout flag; a done strobe beats expiry.
    always_comb begin
        wait_cnt_d = (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
        tmo_err_d  = tmo_err_q | (tmo_hit & ~cos_calc_done);
    end

    // Timeout registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            tmo_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // Next-state and next-value logic for the request/response sequence.
    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        phase_smp_d = phase_smp_q;
        cos_x_d     = cos_x_q;
        neg_d       = neg_q;
        do_calc_d   = 1'b0;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        overrun_d   = overrun_q | (tick & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    phase_smp_d = phase_q[PHASE_W-1 -: SMP_W];
                    phase_d     = phase_q + freq_step;
                    state_d     = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                cos_x_d   = fr_to_angle(red_fr);
                neg_d     = red_neg;
                do_calc_d = 1'b1;  // registered, so the pulse lands in REQ
                state_d   = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cos_calc_done) begin
                    sample_d = neg_q ? -cos_result : cos_result;
                    valid_d  = 1'b1;
                    state_d  = ST_OUT;
                end else if (tmo_hit) begin
                    sample_d = '0;
                    valid_d  = 1'b1;
                    state_d  = ST_OUT;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset clears the request pulse at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            phase_smp_q <= '0;
            cos_x_q     <= '0;
            neg_q       <= 1'b0;
            do_calc_q   <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            phase_smp_q <= phase_smp_d;
            cos_x_q     <= cos_x_d;
            neg_q       <= neg_d;
            do_calc_q   <= do_calc_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;
    assign cos_x        = cos_x_q;
    assign cos_do_calc  = do_calc_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_cos_osc_ctrl.sv
// Self-checking bench for cos_osc_ctrl with a stub cosine ALU.
// The timeout scenario runs only when COS_OSC_TIMEOUT_EN is defined.
module tb_cos_osc_ctrl;

    typedef struct {
        logic [17:0] val;
        bit          chk_lat;
    } exp_s_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [23:0] freq_step;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic [17:0] cos_x;
    logic        cos_do_calc;
    logic [17:0] cos_result;
    logic        cos_calc_done;
    logic [17:0] sample_out;
    logic        sample_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [17:0] exp_x_q[$];
    exp_s_t      exp_s_q[$];
    logic [17:0] last_x = '0;

    int          stub_lat     = 3;
    logic [17:0] stub_val     = '0;
    bit          stub_respond = 1'b1;
    int          done_cyc     = -10;

    cos_osc_ctrl #(
        .PHASE_W        (24),
        .TIMEOUT_CYCLES (63)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .freq_step     (freq_step),
        .busy          (busy),
        .overrun       (overrun),
        .timeout_err   (timeout_err),
        .cos_x         (cos_x),
        .cos_do_calc   (cos_do_calc),
        .cos_result    (cos_result),
        .cos_calc_done (cos_calc_done),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stub ALU: answers each request after stub_lat cycles with stub_val.
    // Outside the strobe the result bus carries junk.
    initial begin
        cos_calc_done = 1'b0;
        cos_result    = 18'h2AAAA;
        forever begin
            @(negedge clk);
            cos_calc_done = 1'b0;
            cos_result    = 18'h2AAAA;
            if (cos_do_calc && stub_respond) begin
                repeat (stub_lat - 1) @(negedge clk);
                cos_result    = stub_val;
                cos_calc_done = 1'b1;
                done_cyc      = cyc;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or a sample.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cos_do_calc) begin
                    if (exp_x_q.size() == 0) begin
                        check("do_calc_unexpected", 32'(cos_do_calc), 32'd0);
                    end else begin
                        last_x = exp_x_q.pop_front();
                        check("cos_x", 32'(cos_x), 32'(last_x));
                    end
                end
                if (sample_valid) begin
                    if (exp_s_q.size() == 0) begin
                        check("sample_valid_unexpected", 32'(sample_valid), 32'd0);
                    end else begin
                        exp_s_t e;
                        e = exp_s_q.pop_front();
                        check("sample_out", 32'(sample_out), 32'(e.val));
                        check("cos_x_stable", 32'(cos_x), 32'(last_x));
                        if (e.chk_lat) check("valid_latency", 32'(cyc), 32'(done_cyc + 1));
                    end
                end
            end
        end
    end

    // Called right after a negedge with the DUT idle; returns in the first WAIT cycle.
    task automatic issue_tick(input logic [17:0] ex, input logic [17:0] es,
                              input bit push_s, input bit chk_lat);
        exp_s_t e;
        exp_x_q.push_back(ex);
        if (push_s) begin
            e.val     = es;
            e.chk_lat = chk_lat;
            exp_s_q.push_back(e);
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("busy_reduce", 32'(busy), 32'd1);
        check("do_calc_t1", 32'(cos_do_calc), 32'd0);
        @(negedge clk);
        check("do_calc_t2", 32'(cos_do_calc), 32'd1);
        @(negedge clk);
        check("do_calc_t3", 32'(cos_do_calc), 32'd0);
    endtask

    // Bounded wait for sample_valid, then one more cycle so the DUT is idle.
    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        while (!sample_valid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!sample_valid) check("valid_wait_expired", 32'(sample_valid), 32'd1);
        @(negedge clk);
        check("idle_after_out", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        tick      = 1'b0;
        freq_step = '0;
        repeat (3) @(negedge clk);

        check("rst_busy",        32'(busy),         32'd0);
        check("rst_overrun",     32'(overrun),      32'd0);
        check("rst_timeout_err", 32'(timeout_err),  32'd0);
        check("rst_do_calc",     32'(cos_do_calc),  32'd0);
        check("rst_valid",       32'(sample_valid), 32'd0);
        check("rst_cos_x",       32'(cos_x),        32'd0);
        check("rst_sample",      32'(sample_out),   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero phase, slow ALU.
        freq_step = 24'h000000;
        stub_lat  = 25;
        stub_val  = 18'h10000;
        issue_tick(18'h00000, 18'h10000, 1'b1, 1'b1);
        wait_valid(60, n);

        // Quarter-turn steps: phase 0 then 0x400000 (q=1, f=0).
        freq_step = 24'h400000;
        stub_lat  = 3;
        issue_tick(18'h00000, 18'h10000, 1'b1, 1'b1);
        wait_valid(20, n);
        stub_val = 18'h00005;
        issue_tick(18'h19220, 18'h3FFFB, 1'b1, 1'b1);
        wait_valid(20, n);

        // Phase 0x800000 (q=2, f=0), then 0xA00000 (q=2, f=0x8000).
        freq_step = 24'h200000;
        stub_val  = 18'h10000;
        issue_tick(18'h00000, 18'h30000, 1'b1, 1'b1);
        wait_valid(20, n);
        freq_step = 24'h100000;
        stub_val  = 18'h0B505;
        issue_tick(18'h0C910, 18'h34AFB, 1'b1, 1'b1);
        wait_valid(20, n);

        // Overrun during WAIT at phase 0xB00000 (q=2, f=0xC000).
        stub_lat = 20;
        issue_tick(18'h12D98, 18'h34AFB, 1'b1, 1'b1);
        check("overrun_before", 32'(overrun), 32'd0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        wait_valid(40, n);

        // Phase advanced once: 0xC00000 (q=3, f=0), positive.
        stub_lat = 3;
        stub_val = 18'h00010;
        issue_tick(18'h19220, 18'h00010, 1'b1, 1'b1);
        wait_valid(20, n);
        check("overrun_sticky", 32'(overrun), 32'd1);

`ifdef COS_OSC_TIMEOUT_EN
        // Timeout at phase 0xD00000 (q=3, f=0x4000 -> fr=0xC000).
        stub_respond = 1'b0;
        issue_tick(18'h12D98, 18'h00000, 1'b1, 1'b0);
        wait_valid(100, n);
        check("timeout_wait_cycles", 32'(n), 32'd63);
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        // Next tick accepted normally: phase 0xE00000 (q=3, f=0x8000).
        stub_respond = 1'b1;
        stub_val     = 18'h0B505;
        issue_tick(18'h0C910, 18'h0B505, 1'b1, 1'b1);
        wait_valid(20, n);
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);
`endif

        // Reset mid-WAIT; the stub's late strobe must not produce a sample.
        stub_lat = 15;
        stub_val = 18'h10000;
`ifdef COS_OSC_TIMEOUT_EN
        issue_tick(18'h06488, 18'h00000, 1'b0, 1'b0);
`else
        issue_tick(18'h12D98, 18'h00000, 1'b0, 1'b0);
`endif
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy",        32'(busy),         32'd0);
        check("mid_rst_do_calc",     32'(cos_do_calc),  32'd0);
        check("mid_rst_valid",       32'(sample_valid), 32'd0);
        check("mid_rst_cos_x",       32'(cos_x),        32'd0);
        check("mid_rst_sample",      32'(sample_out),   32'd0);
        check("mid_rst_overrun",     32'(overrun),      32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Phase was cleared: the next sample is taken at phase 0.
        freq_step = 24'h400000;
        stub_lat  = 3;
        issue_tick(18'h00000, 18'h10000, 1'b1, 1'b1);
        wait_valid(20, n);
        check("overrun_after_rst", 32'(overrun), 32'd0);

`ifndef COS_OSC_TIMEOUT_EN
        check("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif
        check("exp_x_drained", 32'(exp_x_q.size()), 32'd0);
        check("exp_s_drained", 32'(exp_s_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
